// File: rtl/anchor_pkg.sv
// ----------------------------------------------------------------------------
// anchor_pkg
// Shared definitions for the anchor sequencer:
//   - state_t      : sequencer FSM state encoding
//   - STEP_DEFAULT : default anchor_x advance per window (pixels)
//   - WINDOW_ROWS  : rows covered by one filter window
// ----------------------------------------------------------------------------
package anchor_pkg;

    localparam int unsigned STEP_DEFAULT = 16;
    localparam int unsigned WINDOW_ROWS  = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        MOVE    = 3'd2,
        FILTER  = 3'd3,
        ADVANCE = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// ----------------------------------------------------------------------------
// flex_counter
// Generic up-counter with synchronous clear and count enable.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active-high (count -> 0)
//   clear  : synchronous clear, wins over enable
//   enable : increment count by one
//   count  : current count value (wraps at 2**WIDTH)
// ----------------------------------------------------------------------------
module flex_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/anchor_sequencer.sv
// ----------------------------------------------------------------------------
// anchor_sequencer
// Walks a filter anchor across a frame: for each anchor it requests a row
// fetch, pulses the blur controller, waits for it to finish, then advances
// the anchor by STEP columns (or to the next row). Remainder columns that
// cannot hold a full STEP-wide window are skipped.
//
// Optional feature: define ANCHOR_WATCHDOG_EN to compile in a FILTER-phase
// watchdog (WDOG_CYCLES cycles) that sets sticky wdog_err and ends the frame.
//
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   start          : begin frame (IDLE only, ignored while abort is high)
//   abort          : synchronous frame cancel, highest priority
//   img_width/height : frame dimensions, latched on accepted start
//   fetch_req/ack  : row fetch handshake
//   anchor_moving  : one-cycle pulse starting the blur controller
//   anchor_x/y     : current anchor position
//   blur_final     : blur controller finished the current anchor
//   busy           : high outside IDLE
//   frame_done     : one-cycle end-of-frame pulse
//   wdog_err       : sticky watchdog timeout flag (0 when compiled out)
// ----------------------------------------------------------------------------
module anchor_sequencer
    import anchor_pkg::*;
#(
    parameter int unsigned STEP        = STEP_DEFAULT,
    parameter int unsigned WDOG_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] img_width,
    input  logic [15:0] img_height,
    output logic        fetch_req,
    input  logic        fetch_ack,
    output logic        anchor_moving,
    output logic [31:0] anchor_x,
    output logic [31:0] anchor_y,
    input  logic        blur_final,
    output logic        busy,
    output logic        frame_done,
    output logic        wdog_err
);

    localparam logic [31:0] STEP32 = 32'(STEP);

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] width_reg;
    logic [15:0] height_reg;
    logic [31:0] anchor_x_reg;
    logic [31:0] anchor_y_reg;

    logic        start_accept;
    logic        too_small;
    logic        adv_x;
    logic        adv_y;
    logic        wdog_expire;

    assign start_accept = (state_reg == IDLE) && start && !abort;

    // Frames narrower than one window or with no rows produce no anchors.
    assign too_small = ({16'd0, img_width} < STEP32) || (img_height == 16'd0);

    // Another window fits to the right only if its full STEP width is inside.
    assign adv_x = (anchor_x_reg + (STEP32 << 1)) <= {16'd0, width_reg};
    assign adv_y = (anchor_y_reg + 32'd1) < {16'd0, height_reg};

`ifdef ANCHOR_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES) + 1;

    logic [WDOG_W-1:0] wdog_count;
    logic              wdog_err_reg;

    // Held clear outside FILTER so it starts from zero on every FILTER entry.
    flex_counter #(
        .WIDTH (WDOG_W)
    ) u_wdog_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg != FILTER),
        .enable (state_reg == FILTER),
        .count  (wdog_count)
    );

    assign wdog_expire = (state_reg == FILTER) && !blur_final &&
                         (wdog_count == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_err_reg <= 1'b0;
        end else if (start_accept) begin
            wdog_err_reg <= 1'b0;
        end else if (wdog_expire && !abort) begin
            wdog_err_reg <= 1'b1;
        end
    end

    assign wdog_err = wdog_err_reg;
`else
    assign wdog_expire = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and outputs
    always_comb begin
        state_next    = state_reg;
        fetch_req     = 1'b0;
        anchor_moving = 1'b0;
        frame_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_accept) begin
                    state_next = too_small ? DONE : FETCH;
                end
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) begin
                    state_next = MOVE;
                end
            end
            MOVE: begin
                anchor_moving = 1'b1;
                state_next    = FILTER;
            end
            FILTER: begin
                if (blur_final) begin
                    state_next = ADVANCE;
                end else if (wdog_expire) begin
                    state_next = DONE;
                end
            end
            ADVANCE: begin
                state_next = (adv_x || adv_y) ? FETCH : DONE;
            end
            DONE: begin
                // An abort arriving in DONE cancels the end-of-frame pulse.
                frame_done = !abort;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (abort && (state_reg != IDLE)) begin
            state_next = IDLE;
        end
    end

    // Frame dimensions and anchor position; only start and ADVANCE move them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_reg    <= 16'd0;
            height_reg   <= 16'd0;
            anchor_x_reg <= 32'd0;
            anchor_y_reg <= 32'd0;
        end else if (start_accept) begin
            width_reg    <= img_width;
            height_reg   <= img_height;
            anchor_x_reg <= 32'd0;
            anchor_y_reg <= 32'd0;
        end else if ((state_reg == ADVANCE) && !abort) begin
            if (adv_x) begin
                anchor_x_reg <= anchor_x_reg + STEP32;
            end else if (adv_y) begin
                anchor_x_reg <= 32'd0;
                anchor_y_reg <= anchor_y_reg + 32'd1;
            end
        end
    end

    assign anchor_x = anchor_x_reg;
    assign anchor_y = anchor_y_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_anchor_sequencer.sv
// ----------------------------------------------------------------------------
// tb_anchor_sequencer
// Randomized and directed frames for anchor_sequencer. A reference model
// enumerates every anchor of a frame from its dimensions and queues the
// expected anchor_moving / frame_done sequence; a monitor pops and compares
// whenever the DUT pulses either output. Watchdog scenario is included when
// ANCHOR_WATCHDOG_EN is defined.
// ----------------------------------------------------------------------------
module tb_anchor_sequencer;

    localparam int STEP = 16;
    localparam int WDOG = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] img_width = 16'd0;
    logic [15:0] img_height = 16'd0;
    logic        fetch_req;
    logic        fetch_ack = 1'b0;
    logic        anchor_moving;
    logic [31:0] anchor_x;
    logic [31:0] anchor_y;
    logic        blur_final = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        wdog_err;

    anchor_sequencer #(
        .STEP        (STEP),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .img_width     (img_width),
        .img_height    (img_height),
        .fetch_req     (fetch_req),
        .fetch_ack     (fetch_ack),
        .anchor_moving (anchor_moving),
        .anchor_x      (anchor_x),
        .anchor_y      (anchor_y),
        .blur_final    (blur_final),
        .busy          (busy),
        .frame_done    (frame_done),
        .wdog_err      (wdog_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int x;
        int y;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 0;
    bit   hold_ack = 0;
    bit   hold_blur = 0;
    bit   hold_at16 = 0;
    bit   fixed_lat = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model: every window position that fits fully inside the frame,
    // row by row, followed by the end-of-frame marker.
    function automatic void push_frame(input int w, input int h);
        exp_t e;
        if (w >= STEP && h > 0) begin
            for (int y = 0; y < h; y++) begin
                for (int x = 0; x + STEP <= w; x += STEP) begin
                    e.is_done = 0; e.x = x; e.y = y;
                    exp_q.push_back(e);
                end
            end
        end
        e.is_done = 1; e.x = 0; e.y = 0;
        exp_q.push_back(e);
    endfunction

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (anchor_moving) begin
                    $display("txn anchor_moving x=%0d y=%0d", anchor_x, anchor_y);
                    if (exp_q.size() == 0) begin
                        check("unexpected_anchor_qsize", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("anchor_kind_is_done", e.is_done, 0);
                        check("anchor_x", anchor_x, e.x);
                        check("anchor_y", anchor_y, e.y);
                    end
                end
                if (frame_done) begin
                    $display("txn frame_done");
                    if (exp_q.size() == 0) begin
                        check("unexpected_done_qsize", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_kind_is_done", e.is_done, 1);
                    end
                end
            end
        end
    end

    // Fetch responder
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (fetch_req && !hold_ack && !rst) begin
                d = fixed_lat ? 0 : $urandom_range(0, 3);
                repeat (d) @(negedge clk);
                if (fetch_req && !rst) begin
                    fetch_ack = 1'b1;
                    @(negedge clk);
                    fetch_ack = 1'b0;
                end
            end
        end
    end

    // Blur controller responder
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (anchor_moving && !rst && !hold_blur && !(hold_at16 && anchor_x == 32'd16)) begin
                d = fixed_lat ? 3 : $urandom_range(1, 4);
                repeat (d) @(negedge clk);
                blur_final = 1'b1;
                @(negedge clk);
                blur_final = 1'b0;
            end
        end
    end

    task automatic do_start(input int w, input int h);
        @(negedge clk);
        img_width  = 16'(w);
        img_height = 16'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, (n >= 4000) ? 1 : 0, 0);
    endtask

    task automatic wait_moving_x(input int x, input string name);
        int n = 0;
        while (!(anchor_moving && anchor_x == 32'(x)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, (n >= 2000) ? 1 : 0, 0);
    endtask

    // Global time limit
    initial begin
        #2000000;
        failures++;
        $display("FAIL global_timeout actual=expired required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int fd_cycle;
        int fetch_seen;
        int w;
        int h;

        // Reset values
        #12;
        check("rst_busy", busy, 0);
        check("rst_fetch_req", fetch_req, 0);
        check("rst_anchor_moving", anchor_moving, 0);
        check("rst_anchor_x", anchor_x, 0);
        check("rst_anchor_y", anchor_y, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_wdog_err", wdog_err, 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;

        // 32x2 frame, fixed handshake latencies: (0,0),(16,0),(0,1),(16,1)
        fixed_lat = 1;
        push_frame(32, 2);
        do_start(32, 2);
        wait_frame("frame_32x2_timeout");

        // 40x1: remainder columns skipped
        push_frame(40, 1);
        do_start(40, 1);
        wait_frame("frame_40x1_timeout");
        fixed_lat = 0;

        // 8x4: too narrow, DONE directly with no fetch
        push_frame(8, 4);
        fd_cycle = 0;
        fetch_seen = 0;
        @(negedge clk);
        img_width = 16'd8;
        img_height = 16'd4;
        start = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (fetch_req) fetch_seen++;
            if (frame_done && fd_cycle == 0) fd_cycle = k;
        end
        check("narrow_frame_done_cycle", fd_cycle, 2);
        check("narrow_fetch_count", fetch_seen, 0);
        wait_frame("frame_8x4_timeout");

        // Randomized frames
        for (int i = 0; i < 8; i++) begin
            w = $urandom_range(0, 80);
            h = $urandom_range(0, 3);
            $display("txn random_frame w=%0d h=%0d", w, h);
            push_frame(w, h);
            do_start(w, h);
            wait_frame("frame_random_timeout");
        end

        // start together with abort in IDLE is ignored
        @(negedge clk);
        img_width = 16'd32;
        img_height = 16'd1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", busy, 0);
        repeat (3) @(negedge clk);

        // Abort during FILTER at anchor (16,0)
        hold_at16 = 1;
        push_frame(48, 2);
        do_start(48, 2);
        wait_moving_x(16, "wait_anchor16_timeout");
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_q.delete();
        check("abort_busy", busy, 0);
        check("abort_fetch_req", fetch_req, 0);
        repeat (5) @(negedge clk);
        hold_at16 = 0;
        push_frame(32, 1);
        do_start(32, 1);
        wait_frame("frame_after_abort_timeout");

`ifdef ANCHOR_WATCHDOG_EN
        // Watchdog: blur_final withheld
        hold_blur = 1;
        push_frame(16, 1);
        do_start(16, 1);
        wait_moving_x(0, "wait_wdog_anchor_timeout");
        repeat (8) @(negedge clk);
        check("wdog_err_before_expiry", wdog_err, 0);
        @(negedge clk);
        check("wdog_err_set", wdog_err, 1);
        check("wdog_frame_done", frame_done, 1);
        repeat (4) @(negedge clk);
        check("wdog_err_sticky", wdog_err, 1);
        hold_blur = 0;
        push_frame(16, 1);
        do_start(16, 1);
        check("wdog_err_cleared_by_start", wdog_err, 0);
        wait_frame("frame_after_wdog_timeout");
`endif

        // Reset mid-FETCH: outputs drop without a clock edge
        hold_ack = 1;
        push_frame(32, 1);
        do_start(32, 1);
        check("pre_reset_fetch_req", fetch_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_fetch_req", fetch_req, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_anchor_x", anchor_x, 0);
        check("async_rst_anchor_y", anchor_y, 0);
        check("async_rst_frame_done", frame_done, 0);
        check("async_rst_wdog_err", wdog_err, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        hold_ack = 0;
        repeat (3) @(negedge clk);
        check("post_rst_idle_busy", busy, 0);
        push_frame(16, 1);
        do_start(16, 1);
        wait_frame("frame_after_rst_timeout");

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/anchor_sequencer.md
ANCHOR_SEQUENCER -- requirements
Module: anchor_sequencer

Interface
REQ-001 SHALL have parameter STEP, default 16: anchor_x advance per window, in pixels.
REQ-002 SHALL have parameter WDOG_CYCLES, default 1024: filter-phase timeout, used only when the watchdog is compiled in.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port start  input  1  begin frame; sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  synchronous frame cancel.
REQ-007 SHALL have port img_width  input  16  frame width in pixels, latched on accepted start.
REQ-008 SHALL have port img_height  input  16  frame height in rows, latched on accepted start.
REQ-009 SHALL have port fetch_req  output  1  request a new 20-pixel row for the current anchor.
REQ-010 SHALL have port fetch_ack  input  1  fetch complete; blur_in data is valid.
REQ-011 SHALL have port anchor_moving  output  1  one-cycle pulse that starts the blur controller.
REQ-012 SHALL have port anchor_x  output  32  current anchor column.
REQ-013 SHALL have port anchor_y  output  32  current anchor row.
REQ-014 SHALL have port blur_final  input  1  blur controller has finished this anchor.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.
REQ-017 SHALL have port wdog_err  output  1  sticky timeout flag, tied 0 when the watchdog is compiled out.

Function
REQ-018 SHALL implement the states IDLE, FETCH, MOVE, FILTER, ADVANCE and DONE.
REQ-019 SHALL, in IDLE, on start, latch the dimensions, set anchor to (0,0), and go to FETCH; if img_width<STEP or img_height==0, it SHALL go to DONE instead, with no fetch.
REQ-020 SHALL hold fetch_req high throughout FETCH, go to MOVE on the cycle after fetch_ack=1, and drop fetch_req in that same cycle.
REQ-021 SHALL assert anchor_moving for exactly one cycle in MOVE, then go to FILTER.
REQ-022 SHALL hold anchor_x and anchor_y constant from FETCH through FILTER.
REQ-023 SHALL leave FILTER for ADVANCE on blur_final=1.
REQ-024 SHALL, in ADVANCE, apply the first matching rule:
- if anchor_x+2*STEP <= width: anchor_x += STEP, then go to FETCH.
- else if anchor_y+1 < height: anchor_x=0, anchor_y += 1, then go to FETCH.
- otherwise: go to DONE.
REQ-025 SHALL leave any remainder columns (width mod STEP) unvisited.
REQ-026 SHALL pulse frame_done for one cycle in DONE, then go to IDLE.
REQ-027 SHALL, on abort in any non-IDLE state, go to IDLE on the next edge with fetch_req=0 and without pulsing frame_done; abort SHALL take priority over every other transition.
REQ-028 SHALL ignore start when not in IDLE, fetch_ack outside FETCH, and blur_final outside FILTER.
REQ-029 SHALL, when start and abort are both high in IDLE, ignore start.
REQ-030 SHALL perform all anchor arithmetic at 32-bit width, zero-extending the 16-bit dimensions.

Reset
REQ-031 SHALL, on rst, go to state IDLE and drive fetch_req=0, anchor_moving=0, anchor_x=0, anchor_y=0, busy=0, frame_done=0 and wdog_err=0.
REQ-032 SHALL, on reset mid-frame, discard the latched dimensions; the frame is not resumed.

Configuration
REQ-033 SHALL compile the watchdog in when ANCHOR_WATCHDOG_EN is defined; in that case:
- a counter SHALL clear on entry to FILTER and increment each cycle in FILTER.
- if the count reaches WDOG_CYCLES-1 without blur_final, wdog_err SHALL set and the block SHALL go to DONE.
- wdog_err SHALL clear only on rst or on an accepted start.
REQ-034 SHALL, without ANCHOR_WATCHDOG_EN, contain no watchdog counter; wdog_err SHALL be constant 0 and FILTER SHALL wait indefinitely.

Structure
REQ-035 SHALL take the state enum type and constants STEP_DEFAULT=16 and WINDOW_ROWS=5 from a shared package, anchor_pkg.
REQ-036 SHALL implement the watchdog counter with one instance of the existing flex_counter sub-module; no other sub-modules.

Verification
REQ-037 SHALL cover: width=32, height=2, fetch_ack one cycle after each request, blur_final 3 cycles after each anchor_moving -> anchors (0,0),(16,0),(0,1),(16,1) in that order, 4 anchor_moving pulses, then exactly one frame_done.
REQ-038 SHALL cover: width=40, height=1 -> anchors (0,0) and (16,0) only; frame_done follows the second anchor's blur_final.
REQ-039 SHALL cover: width=8, height=4, start -> frame_done on the 2nd cycle after start, with fetch_req never asserted.
REQ-040 SHALL cover: abort during FILTER at anchor (16,0) -> busy=0 on the next cycle, no frame_done; a following start restarts at (0,0).
REQ-041 SHALL cover, with ANCHOR_WATCHDOG_EN and WDOG_CYCLES=8: blur_final withheld -> wdog_err=1 after 8 FILTER cycles, then frame_done, and wdog_err stays 1 until the next start.
REQ-042 SHALL cover: rst asserted mid-FETCH -> all outputs take their reset values immediately, with no clock edge required.
